// File: rtl/pipe_pkg.sv
// Shared types and constants for the MEM->WB pipeline register.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned STAGES_MAX     = 4;

  typedef struct packed {
    logic [DATA_W_DEF-1:0]     read_data;
    logic [DATA_W_DEF-1:0]     alu_result;
    logic [REG_ADDR_W_DEF-1:0] write_reg;
    logic                      memtoreg;
    logic                      regwrite;
  } mem_wb_payload_t;

  // A write to the hard-wired zero register is a no-op, so drop its enable early.
  function automatic logic qualify_regwrite(input logic regwrite,
                                            input logic suppress,
                                            input logic is_zero_reg);
    logic result;
    if (suppress && is_zero_reg) begin
      result = 1'b0;
    end else begin
      result = regwrite;
    end
    return result;
  endfunction

endpackage

// File: rtl/pipe_skid_slice.sv
// One valid/ready register slice with a skid entry and a synchronous flush.
// Upstream ready is registered (!skid_valid), so out_ready never reaches in_ready combinationally.
module pipe_skid_slice
  import pipe_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] main_data_q,  main_data_d;
  logic [W-1:0] skid_data_q,  skid_data_d;
  logic         accept_s, drain_s;
  logic         main_load_s, skid_load_s, main_from_skid_s;

  // Entry movement between input, main and skid; flush kills every valid and every load.
  always_comb begin
    accept_s         = in_valid & ~skid_valid_q;
    drain_s          = main_valid_q & out_ready;
    main_load_s      = 1'b0;
    skid_load_s      = 1'b0;
    main_from_skid_s = 1'b0;
    main_valid_d     = main_valid_q;
    skid_valid_d     = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain_s) begin
      if (skid_valid_q) begin
        main_from_skid_s = 1'b1;
        main_valid_d     = 1'b1;
        skid_valid_d     = 1'b0;
      end else if (accept_s) begin
        main_load_s  = 1'b1;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept_s) begin
      skid_load_s  = 1'b1;
      skid_valid_d = 1'b1;
    end else begin
      skid_valid_d = skid_valid_q;
    end
  end

  // Payload registers change only on their own load enable.
  always_comb begin
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (main_from_skid_s) begin
      main_data_d = skid_data_q;
    end else if (main_load_s) begin
      main_data_d = in_data;
    end else begin
      main_data_d = main_data_q;
    end
    if (skid_load_s) begin
      skid_data_d = in_data;
    end else begin
      skid_data_d = skid_data_q;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register: STAGES chained skid slices carrying load data, ALU result and WB controls.
// Optional performance counters are built when MEM_WB_PIPE_PERF_EN is defined.
module mem_wb_pipe
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W            = 32,
  parameter int unsigned REG_ADDR_W        = 5,
  parameter int unsigned STAGES            = 1,
  parameter bit          ZERO_REG_SUPPRESS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_read_data,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [REG_ADDR_W-1:0] in_write_reg,
  input  logic                  in_memtoreg,
  input  logic                  in_regwrite,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_read_data,
  output logic [DATA_W-1:0]     out_alu_result,
  output logic [REG_ADDR_W-1:0] out_write_reg,
  output logic                  out_memtoreg,
  output logic                  out_regwrite
`ifdef MEM_WB_PIPE_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_retire_cnt
`endif
);

  // Out-of-range STAGES values are clamped to the legal 1..STAGES_MAX window.
  localparam int unsigned N  = (STAGES < 1) ? 1 : ((STAGES > STAGES_MAX) ? STAGES_MAX : STAGES);
  localparam int unsigned PW = 2 * DATA_W + REG_ADDR_W + 2;

  logic          link_valid [N+1];
  logic          link_ready [N+1];
  logic [PW-1:0] link_data  [N+1];
  logic          regwrite_in_s;
  logic          regwrite_out_s;

  assign regwrite_in_s = qualify_regwrite(in_regwrite, ZERO_REG_SUPPRESS,
                                          (in_write_reg == {REG_ADDR_W{1'b0}}));

  assign link_valid[0] = in_valid;
  assign link_data[0]  = {in_read_data, in_alu_result, in_write_reg, in_memtoreg, regwrite_in_s};
  assign in_ready      = link_ready[0];
  assign link_ready[N] = out_ready;

  for (genvar k = 0; k < N; k++) begin : g_slice
    pipe_skid_slice #(.W(PW)) u_slice (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (link_valid[k]),
      .in_ready  (link_ready[k]),
      .in_data   (link_data[k]),
      .out_valid (link_valid[k+1]),
      .out_ready (link_ready[k+1]),
      .out_data  (link_data[k+1])
    );
  end

  assign {out_read_data, out_alu_result, out_write_reg, out_memtoreg, regwrite_out_s} = link_data[N];
  assign out_valid    = link_valid[N];
  assign out_regwrite = link_valid[N] & regwrite_out_s;

`ifdef MEM_WB_PIPE_PERF_EN
  logic [31:0] perf_stall_cnt_q,  perf_stall_cnt_d;
  logic [31:0] perf_retire_cnt_q, perf_retire_cnt_d;

  // Counters wrap naturally; flush leaves them alone.
  always_comb begin
    perf_stall_cnt_d  = perf_stall_cnt_q;
    perf_retire_cnt_d = perf_retire_cnt_q;
    if (out_valid && !out_ready) begin
      perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
    end else begin
      perf_stall_cnt_d = perf_stall_cnt_q;
    end
    if (out_valid && out_ready && out_regwrite) begin
      perf_retire_cnt_d = perf_retire_cnt_q + 32'd1;
    end else begin
      perf_retire_cnt_d = perf_retire_cnt_q;
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt_q  <= 32'd0;
      perf_retire_cnt_q <= 32'd0;
    end else begin
      perf_stall_cnt_q  <= perf_stall_cnt_d;
      perf_retire_cnt_q <= perf_retire_cnt_d;
    end
  end

  assign perf_stall_cnt  = perf_stall_cnt_q;
  assign perf_retire_cnt = perf_retire_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench: u_a is STAGES=2 with zero-reg suppression, u_b is STAGES=1 without it.
module tb_mem_wb_pipe;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_memtoreg, in_regwrite;
  logic [31:0] in_read_data, in_alu_result;
  logic [4:0]  in_write_reg;

  logic        a_in_ready, a_out_valid, a_out_ready, a_out_memtoreg, a_out_regwrite;
  logic [31:0] a_out_read_data, a_out_alu_result;
  logic [4:0]  a_out_write_reg;
  logic        b_in_ready, b_out_valid, b_out_ready, b_out_memtoreg, b_out_regwrite;
  logic [31:0] b_out_read_data, b_out_alu_result;
  logic [4:0]  b_out_write_reg;
`ifdef MEM_WB_PIPE_PERF_EN
  logic [31:0] a_stall, a_retire, b_stall, b_retire;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_wb_pipe #(.DATA_W(32), .REG_ADDR_W(5), .STAGES(2), .ZERO_REG_SUPPRESS(1'b1)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_read_data(in_read_data), .in_alu_result(in_alu_result), .in_write_reg(in_write_reg),
    .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_read_data(a_out_read_data), .out_alu_result(a_out_alu_result),
    .out_write_reg(a_out_write_reg), .out_memtoreg(a_out_memtoreg), .out_regwrite(a_out_regwrite)
`ifdef MEM_WB_PIPE_PERF_EN
    , .perf_stall_cnt(a_stall), .perf_retire_cnt(a_retire)
`endif
  );

  mem_wb_pipe #(.DATA_W(32), .REG_ADDR_W(5), .STAGES(1), .ZERO_REG_SUPPRESS(1'b0)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_read_data(in_read_data), .in_alu_result(in_alu_result), .in_write_reg(in_write_reg),
    .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_read_data(b_out_read_data), .out_alu_result(b_out_alu_result),
    .out_write_reg(b_out_write_reg), .out_memtoreg(b_out_memtoreg), .out_regwrite(b_out_regwrite)
`ifdef MEM_WB_PIPE_PERF_EN
    , .perf_stall_cnt(b_stall), .perf_retire_cnt(b_retire)
`endif
  );

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] wr, input logic rw);
    in_valid      = v;
    in_alu_result = alu;
    in_read_data  = ~alu;
    in_write_reg  = wr;
    in_memtoreg   = alu[0];
    in_regwrite   = rw;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 5'd7, 1'b1);
    tick(); tick(); tick();
    total++;
    if ({a_out_valid, a_out_regwrite, a_out_memtoreg, a_out_write_reg, a_out_read_data, a_out_alu_result} !== 72'h0) begin
      bad++;
      $display("FAIL reset_a_outputs got=%h want=0", {a_out_valid, a_out_regwrite, a_out_memtoreg, a_out_write_reg, a_out_read_data, a_out_alu_result});
    end
    total++;
    if ({b_out_valid, b_out_regwrite, b_out_memtoreg, b_out_write_reg, b_out_read_data, b_out_alu_result} !== 72'h0) begin
      bad++;
      $display("FAIL reset_b_outputs got=%h want=0", {b_out_valid, b_out_regwrite, b_out_memtoreg, b_out_write_reg, b_out_read_data, b_out_alu_result});
    end
    rst = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    total++;
    if ({a_in_ready, b_in_ready, a_out_valid, b_out_valid} !== 4'b1100) begin
      bad++;
      $display("FAIL reset_release got rdy/vld=%b want=1100", {a_in_ready, b_in_ready, a_out_valid, b_out_valid});
    end
  endtask

  task automatic test_streaming();
    mem_wb_payload_t q[$];
    mem_wb_payload_t exp;
    do_reset();
    a_out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      drive(c < 3, 32'h10 + 32'(c), 5'd4, 1'b1);
      total++;
      if (a_in_ready !== 1'b1) begin
        bad++;
        $display("FAIL stream_in_ready cyc=%0d got=%b want=1", c, a_in_ready);
      end
      total++;
      if (a_out_valid !== ((c >= 2) && (c < 5))) begin
        bad++;
        $display("FAIL stream_valid cyc=%0d got=%b want=%b", c, a_out_valid, (c >= 2) && (c < 5));
      end
      if (a_out_valid && q.size() > 0) begin
        exp = q.pop_front();
        total++;
        if (a_out_alu_result !== exp.alu_result) begin
          bad++;
          $display("FAIL stream_data cyc=%0d got=%h want=%h", c, a_out_alu_result, exp.alu_result);
        end
      end
      if (in_valid) begin
        exp = '0;
        exp.alu_result = in_alu_result;
        q.push_back(exp);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic        exp_rdy [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        exp_vld [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp_alu [7] = '{32'h0, 32'hA, 32'hA, 32'hA, 32'hA, 32'hB, 32'h0};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      b_out_ready = (c >= 4);
      drive(c < 2, (c == 0) ? 32'hA : 32'hB, 5'd2, 1'b1);
      total++;
      if (b_in_ready !== exp_rdy[c]) begin
        bad++;
        $display("FAIL bp_in_ready cyc=%0d got=%b want=%b", c, b_in_ready, exp_rdy[c]);
      end
      total++;
      if (b_out_valid !== exp_vld[c]) begin
        bad++;
        $display("FAIL bp_valid cyc=%0d got=%b want=%b", c, b_out_valid, exp_vld[c]);
      end
      if (exp_vld[c]) begin
        total++;
        if (b_out_alu_result !== exp_alu[c]) begin
          bad++;
          $display("FAIL bp_data cyc=%0d got=%h want=%h", c, b_out_alu_result, exp_alu[c]);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    mem_wb_payload_t q[$];
    mem_wb_payload_t exp, item;
    int sent = 0;
    int got  = 0;
    do_reset();
    a_out_ready = 1'b1;
    for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
      b_out_ready = ($urandom_range(0, 3) != 0);
      if (b_out_valid && b_out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rand_extra_entry got=%h want=none", b_out_alu_result);
        end else begin
          exp = q.pop_front();
          got++;
          if ({b_out_read_data, b_out_alu_result, b_out_write_reg, b_out_memtoreg, b_out_regwrite} !== exp) begin
            bad++;
            $display("FAIL rand_payload n=%0d got=%h want=%h", got,
                     {b_out_read_data, b_out_alu_result, b_out_write_reg, b_out_memtoreg, b_out_regwrite}, exp);
          end
        end
      end
      if (!b_out_valid) begin
        total++;
        if (b_out_regwrite !== 1'b0) begin
          bad++;
          $display("FAIL rand_regwrite_idle got=%b want=0", b_out_regwrite);
        end
      end
      drive((sent < 1000) && ($urandom_range(0, 3) != 0), $urandom(),
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom()), 1'($urandom()));
      in_read_data = $urandom();
      if (in_valid && b_in_ready) begin
        item.read_data  = in_read_data;
        item.alu_result = in_alu_result;
        item.write_reg  = in_write_reg;
        item.memtoreg   = in_memtoreg;
        item.regwrite   = in_regwrite;
        q.push_back(item);
        sent++;
      end
      tick();
    end
    total++;
    if (got != 1000 || q.size() != 0) begin
      bad++;
      $display("FAIL rand_complete got=%0d left=%0d want=1000/0", got, q.size());
    end
    drive(1'b0, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic test_zero_reg();
    do_reset();
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 0) drive(1'b1, 32'h55, 5'd0, 1'b1);
      else if (c == 1) drive(1'b1, 32'h66, 5'd3, 1'b1);
      else drive(1'b0, 32'h0, 5'd0, 1'b0);
      if (c == 1) begin
        total++;
        if ({b_out_valid, b_out_regwrite, b_out_write_reg} !== {1'b1, 1'b1, 5'd0}) begin
          bad++;
          $display("FAIL zero_no_suppress got=%b want=1100000", {b_out_valid, b_out_regwrite, b_out_write_reg});
        end
      end
      if (c == 2) begin
        total++;
        if ({a_out_valid, a_out_regwrite, a_out_write_reg, a_out_memtoreg, a_out_alu_result} !== {1'b1, 1'b0, 5'd0, 1'b1, 32'h55}) begin
          bad++;
          $display("FAIL zero_suppress got=%h want=%h", {a_out_valid, a_out_regwrite, a_out_write_reg, a_out_memtoreg, a_out_alu_result},
                   {1'b1, 1'b0, 5'd0, 1'b1, 32'h55});
        end
      end
      if (c == 3) begin
        total++;
        if ({a_out_valid, a_out_regwrite, a_out_write_reg} !== {1'b1, 1'b1, 5'd3}) begin
          bad++;
          $display("FAIL zero_nonzero_reg got=%b want=1100011", {a_out_valid, a_out_regwrite, a_out_write_reg});
        end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    do_reset();
    a_out_ready = 1'b0;
    for (int c = 0; c < 17; c++) begin
      flush = (c == 3);
      if (c == 4) a_out_ready = 1'b1;
      drive((c < 4) || (c == 13), (c == 13) ? 32'h30 : 32'h20 + 32'(c), 5'd9, 1'b1);
      if (c == 2 || c == 3) begin
        total++;
        if (a_in_ready !== 1'b1) begin
          bad++;
          $display("FAIL flush_pre_ready cyc=%0d got=%b want=1", c, a_in_ready);
        end
      end
      if (c == 3) begin
        total++;
        if ({a_out_valid, a_out_alu_result} !== {1'b1, 32'h20}) begin
          bad++;
          $display("FAIL flush_pre_head got=%h want=%h", {a_out_valid, a_out_alu_result}, {1'b1, 32'h20});
        end
      end
      if (c == 4) begin
        total++;
        if ({a_in_ready, a_out_valid} !== 2'b10) begin
          bad++;
          $display("FAIL flush_after got rdy/vld=%b want=10", {a_in_ready, a_out_valid});
        end
      end
      if (c > 4 && c != 15) begin
        total++;
        if (a_out_valid !== 1'b0) begin
          bad++;
          $display("FAIL flush_leak cyc=%0d got=%h want=no entry", c, a_out_alu_result);
        end
      end
      if (c == 15) begin
        total++;
        if ({a_out_valid, a_out_alu_result} !== {1'b1, 32'h30}) begin
          bad++;
          $display("FAIL flush_recover got=%h want=%h", {a_out_valid, a_out_alu_result}, {1'b1, 32'h30});
        end
      end
      tick();
    end
    flush = 1'b0;
  endtask

`ifdef MEM_WB_PIPE_PERF_EN
  task automatic test_perf();
    do_reset();
    for (int c = 0; c < 11; c++) begin
      a_out_ready = (c >= 7);
      drive(c < 3, 32'h40 + 32'(c), 5'd1 + 5'(c), 1'b1);
      if (c == 10) begin
        total++;
        if ({a_stall, a_retire, a_out_valid} !== {32'd5, 32'd3, 1'b0}) begin
          bad++;
          $display("FAIL perf_counts got stall=%0d retire=%0d want 5/3", a_stall, a_retire);
        end
      end
      tick();
    end
    a_out_ready = 1'b0;
    drive(1'b1, 32'h50, 5'd6, 1'b1);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    u_a.perf_stall_cnt_q = 32'hFFFF_FFFF;
    tick();
    total++;
    if (a_stall !== 32'd0) begin
      bad++;
      $display("FAIL perf_wrap got=%h want=0", a_stall);
    end
    a_out_ready = 1'b1;
    tick();
    total++;
    if (a_retire !== 32'd4) begin
      bad++;
      $display("FAIL perf_retire_after got=%0d want=4", a_retire);
    end
  endtask
`endif

  initial begin
    flush = 1'b0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_random();
    test_zero_reg();
    test_flush();
`ifdef MEM_WB_PIPE_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised MEM->WB pipeline register with a valid/ready handshake, a skid buffer for backpressure, and a synchronous flush.
- Carries the load data, ALU result, destination register index and the MemtoReg/RegWrite controls.
- Supports a configurable number of back-to-back register slices, so a multi-cycle memory path or a stalling writeback port can sit between MEM and WB.

Parameters:
- DATA_W, 32, width of read_data and alu_result
- REG_ADDR_W, 5, width of the destination register index
- STAGES, 1, number of chained slices (legal range 1..4); latency in cycles when unstalled
- ZERO_REG_SUPPRESS, 1, when 1, RegWrite to register index 0 is forced to 0 at the input

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  discard every in-flight entry
- in_valid  in  1  MEM stage presents an entry
- in_ready  out  1  block accepts an entry this cycle
- in_read_data  in  DATA_W  memory load data
- in_alu_result  in  DATA_W  ALU result
- in_write_reg  in  REG_ADDR_W  destination register
- in_memtoreg  in  1  select load data at WB
- in_regwrite  in  1  write enable for the destination register
- out_valid  out  1  WB entry valid
- out_ready  in  1  WB consumes the entry
- out_read_data  out  DATA_W  load data
- out_alu_result  out  DATA_W  ALU result
- out_write_reg  out  REG_ADDR_W  destination register
- out_memtoreg  out  1  MemtoReg control
- out_regwrite  out  1  write enable, already qualified by out_valid

Behaviour:
- Interface decisions (fixed): one clock, clk; reset rst is synchronous and active-high. All state changes happen on the posedge of clk.
- Reset:
  - Every slice's main_valid and skid_valid = 0.
  - All payload registers = 0.
  - Outputs: out_valid=0, out_regwrite=0, out_memtoreg=0, out_write_reg=0, out_read_data=0, out_alu_result=0.
  - in_ready=1 in the first cycle after reset.
- Reset takes priority over flush and over any handshake. Reset asserted mid-transfer drops the entry; no partial state survives.
- Handshake terms:
  - Transfer in: in_valid & in_ready.
  - Transfer out: out_valid & out_ready.
  - in_valid is not required to be held, and the payload may change while in_valid=0.
- Each slice holds two entries: main and skid.
  - Slice ready = !skid_valid. It is registered, with no combinational path from out_ready to in_ready.
  - Accept while main is empty, or while main drains the same cycle: load main.
  - Accept while main is held: load skid.
  - Downstream fire with skid_valid=1: skid moves to main; skid_valid=0.
  - Downstream fire with no accept and no skid: main_valid=0.
- Chaining: slice k's output drives slice k+1's input. Output ports come from the last slice's main register.
- Latency: STAGES cycles from transfer in to out_valid while unstalled. Throughput is 1 entry/cycle.
- Capacity: 2*STAGES entries. Zero loss and no duplication under any out_ready pattern.
- out_regwrite = main_valid & stored regwrite. It is never 1 while out_valid=0.
- ZERO_REG_SUPPRESS=1: an entry with in_write_reg==0 is captured with regwrite=0; the rest of its payload is unchanged.
- flush:
  - Clears every main_valid and skid_valid at the clock edge.
  - An in_valid arriving in the same cycle is dropped. in_ready still shows its pre-flush value, so upstream must itself squash that cycle.
  - Payload registers are left as they are; they are don't-care while invalid.
  - The cycle after a flush, in_ready=1 and out_valid=0.
- Payload registers load only on their own load enable. They hold their value while stalled.

Optional Feature:
- Macro: MEM_WB_PIPE_PERF_EN.
- When defined, the following are added:
  - Output perf_stall_cnt (32 bits): increments each cycle with out_valid & !out_ready.
  - Output perf_retire_cnt (32 bits): increments on each transfer out with out_regwrite=1.
  - Both counters wrap at 2^32 and are cleared by rst. flush does not clear them.
- When undefined: those ports and counters do not exist, and there is no logic cost.

Decomposition:
- Shared package pipe_pkg:
  - localparam DATA_W_DEF=32, REG_ADDR_W_DEF=5.
  - Packed struct typedef mem_wb_payload_t {read_data, alu_result, write_reg, memtoreg, regwrite}, built from the defaults.
  - STAGES_MAX=4.
- One sub-module, pipe_skid_slice: a generic payload width, one slice, with flush. It is instantiated STAGES times in a generate loop.

Test Plan:
- Reset: hold rst=1 with in_valid=1 -> all outputs are 0, out_valid=0; in_ready=1 in the cycle after rst falls.
- Streaming, STAGES=2, out_ready=1: send alu_result 0x10,0x11,0x12 on consecutive cycles -> they appear 2 cycles later, in order, on consecutive cycles with no gap.
- Backpressure, STAGES=1: out_ready=0 while sending 0xA,0xB -> in_ready falls after the 2nd accept and 0xA is held. Raise out_ready -> 0xA, then 0xB, no loss or duplication. Then a random out_ready pattern over 1000 entries -> scoreboard matches exactly.
- Zero register: in_write_reg=0, in_regwrite=1, ZERO_REG_SUPPRESS=1 -> out_regwrite=0 with out_valid=1. With ZERO_REG_SUPPRESS=0 -> out_regwrite=1.
- Flush: with 3 entries in flight (STAGES=2, stalled), pulse flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and none of the 4 entries ever appears.
- Perf (MEM_WB_PIPE_PERF_EN): stall 5 cycles, then retire 3 entries with regwrite=1 -> perf_stall_cnt=5, perf_retire_cnt=3. Preload 0xFFFFFFFF and stall one cycle -> wraps to 0.
